// File: rtl/axis_snoop_pkg.sv
// Types and constants shared by the snoop arbiter and the snoop demux.
package axis_snoop_pkg;

    localparam int MAX_INTERFACES = 4;
    localparam int DEST_W         = 2;

    typedef enum logic [1:0] {SOP, FWD, DROP} state_t;

    function automatic logic dest_populated(input logic [DEST_W-1:0] dest, input int num_if);
        return int'(dest) < num_if;
    endfunction

endpackage

// File: rtl/axis_snoop_out_reg.sv
// Single-slot AXI-Stream output register; dest rides along as sideband.
module axis_snoop_out_reg
    import axis_snoop_pkg::*;
#(
    parameter int PORT_WIDTH = 8
) (
    input  logic                  axis_aclk,
    input  logic                  axis_aresetn,
    input  logic                  load,
    input  logic                  retire,
    input  logic [PORT_WIDTH-1:0] load_data,
    input  logic                  load_last,
    input  logic [DEST_W-1:0]     load_dest,
    output logic                  out_valid,
    output logic [PORT_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [DEST_W-1:0]     out_dest
);

    // Load wins over retire so a simultaneous retire+accept reloads without a bubble.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_dest  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_last  <= load_last;
            out_dest  <= load_dest;
        end else if (retire) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_snoop_demux.sv
// Routes whole AXI-Stream packets to one of up to four master ports by tdest.
// Optional drop counter enabled by defining AXIS_SNOOP_DEMUX_STATS_EN.
module axis_snoop_demux
    import axis_snoop_pkg::*;
#(
    parameter int NUM_INTERFACES = 2,
    parameter int PORT_WIDTH     = 8
) (
    input  logic                  axis_aclk,
    input  logic                  axis_aresetn,
    input  logic [PORT_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    input  logic [1:0]            s_axis_tdest,
    output logic                  s_axis_tready,
    output logic [PORT_WIDTH-1:0] m00_axis_tdata,
    output logic                  m00_axis_tlast,
    output logic                  m00_axis_tvalid,
    input  logic                  m00_axis_tready,
    output logic [PORT_WIDTH-1:0] m01_axis_tdata,
    output logic                  m01_axis_tlast,
    output logic                  m01_axis_tvalid,
    input  logic                  m01_axis_tready,
    output logic [PORT_WIDTH-1:0] m02_axis_tdata,
    output logic                  m02_axis_tlast,
    output logic                  m02_axis_tvalid,
    input  logic                  m02_axis_tready,
    output logic [PORT_WIDTH-1:0] m03_axis_tdata,
    output logic                  m03_axis_tlast,
    output logic                  m03_axis_tvalid,
    input  logic                  m03_axis_tready
`ifdef AXIS_SNOOP_DEMUX_STATS_EN
    ,
    output logic [15:0]           drop_pkt_count
`endif
);

    localparam logic [MAX_INTERFACES-1:0] POP_MASK =
        MAX_INTERFACES'((1 << NUM_INTERFACES) - 1);

    state_t                                     state;
    logic [MAX_INTERFACES-1:0]                  m_tready;
    logic [MAX_INTERFACES-1:0]                  m_tvalid;
    logic [MAX_INTERFACES-1:0]                  m_tlast;
    logic [MAX_INTERFACES-1:0][PORT_WIDTH-1:0]  m_tdata;

    logic                  out_valid;
    logic [PORT_WIDTH-1:0] out_data;
    logic                  out_last;
    logic [DEST_W-1:0]     out_dest;
    logic                  out_ready;
    logic                  accept;
    logic                  dest_ok;
    logic                  load;
    logic                  retire;
    logic [DEST_W-1:0]     load_dest;

    assign m_tready = {m03_axis_tready, m02_axis_tready, m01_axis_tready, m00_axis_tready};

    // Tied-off ports never see traffic, so their tready is masked away.
    assign out_ready = m_tready[out_dest] & POP_MASK[out_dest];
    assign retire    = out_valid & out_ready;

    assign s_axis_tready = axis_aresetn & ((state == DROP) | ~out_valid | out_ready);
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign dest_ok       = dest_populated(s_axis_tdest, NUM_INTERFACES);

    assign load      = accept & (((state == SOP) & dest_ok) | (state == FWD));
    assign load_dest = (state == SOP) ? s_axis_tdest : out_dest;

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state <= SOP;
        end else if (accept) begin
            case (state)
                SOP:       if (!s_axis_tlast) state <= dest_ok ? FWD : DROP;
                FWD, DROP: if (s_axis_tlast)  state <= SOP;
                default:   state <= SOP;
            endcase
        end
    end

    axis_snoop_out_reg #(
        .PORT_WIDTH(PORT_WIDTH)
    ) u_out_reg (
        .axis_aclk    (axis_aclk),
        .axis_aresetn (axis_aresetn),
        .load         (load),
        .retire       (retire),
        .load_data    (s_axis_tdata),
        .load_last    (s_axis_tlast),
        .load_dest    (load_dest),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_dest     (out_dest)
    );

    for (genvar gi = 0; gi < MAX_INTERFACES; gi++) begin : g_port
        if (gi < NUM_INTERFACES) begin : g_pop
            logic sel;
            assign sel          = (out_dest == DEST_W'(gi));
            assign m_tvalid[gi] = out_valid & sel;
            assign m_tdata[gi]  = sel ? out_data : '0;
            assign m_tlast[gi]  = sel & out_last;
        end else begin : g_tie
            assign m_tvalid[gi] = 1'b0;
            assign m_tdata[gi]  = '0;
            assign m_tlast[gi]  = 1'b0;
        end
    end

    assign m00_axis_tvalid = m_tvalid[0];
    assign m00_axis_tdata  = m_tdata[0];
    assign m00_axis_tlast  = m_tlast[0];
    assign m01_axis_tvalid = m_tvalid[1];
    assign m01_axis_tdata  = m_tdata[1];
    assign m01_axis_tlast  = m_tlast[1];
    assign m02_axis_tvalid = m_tvalid[2];
    assign m02_axis_tdata  = m_tdata[2];
    assign m02_axis_tlast  = m_tlast[2];
    assign m03_axis_tvalid = m_tvalid[3];
    assign m03_axis_tdata  = m_tdata[3];
    assign m03_axis_tlast  = m_tlast[3];

`ifdef AXIS_SNOOP_DEMUX_STATS_EN
    // Counts packets, not beats: only the first beat of a dropped packet.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            drop_pkt_count <= '0;
        end else if (accept && (state == SOP) && !dest_ok && (drop_pkt_count != 16'hFFFF)) begin
            drop_pkt_count <= drop_pkt_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_snoop_demux.sv
// Self-checking bench for axis_snoop_demux: vector table plus scoreboard.
module tb_axis_snoop_demux;

    localparam int NI = 2;
    localparam int PW = 8;

    logic            axis_aclk    = 1'b0;
    logic            axis_aresetn = 1'b0;
    logic [PW-1:0]   s_tdata      = '0;
    logic            s_tlast      = 1'b0;
    logic            s_tvalid     = 1'b0;
    logic [1:0]      s_tdest      = '0;
    wire             s_tready;
    logic [3:0]      m_ready      = 4'hF;
    wire  [3:0]      m_valid;
    wire  [3:0]      m_last;
    wire  [3:0][PW-1:0] m_data;
`ifdef AXIS_SNOOP_DEMUX_STATS_EN
    wire  [15:0]     drop_cnt;
`endif

    axis_snoop_demux #(.NUM_INTERFACES(NI), .PORT_WIDTH(PW)) dut (
        .axis_aclk       (axis_aclk),
        .axis_aresetn    (axis_aresetn),
        .s_axis_tdata    (s_tdata),
        .s_axis_tlast    (s_tlast),
        .s_axis_tvalid   (s_tvalid),
        .s_axis_tdest    (s_tdest),
        .s_axis_tready   (s_tready),
        .m00_axis_tdata  (m_data[0]),
        .m00_axis_tlast  (m_last[0]),
        .m00_axis_tvalid (m_valid[0]),
        .m00_axis_tready (m_ready[0]),
        .m01_axis_tdata  (m_data[1]),
        .m01_axis_tlast  (m_last[1]),
        .m01_axis_tvalid (m_valid[1]),
        .m01_axis_tready (m_ready[1]),
        .m02_axis_tdata  (m_data[2]),
        .m02_axis_tlast  (m_last[2]),
        .m02_axis_tvalid (m_valid[2]),
        .m02_axis_tready (m_ready[2]),
        .m03_axis_tdata  (m_data[3]),
        .m03_axis_tlast  (m_last[3]),
        .m03_axis_tvalid (m_valid[3]),
        .m03_axis_tready (m_ready[3])
`ifdef AXIS_SNOOP_DEMUX_STATS_EN
        ,
        .drop_pkt_count  (drop_cnt)
`endif
    );

    always #5 axis_aclk = ~axis_aclk;

    int cyc = 0;
    always @(posedge axis_aclk) cyc <= cyc + 1;

    typedef struct {
        int        port;
        logic [7:0] data;
        logic      last;
        int        cyc;
        bit        chk_lat;
    } sb_t;

    typedef struct {
        logic [1:0] dest;
        logic [7:0] data;
        logic       last;
        int         exp_port;   // -1: packet must be dropped
    } vec_t;

    sb_t sbq[$];
    int  errs   = 0;
    int  checks = 0;
    int  last_wait = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Retired output beats are matched in order against the scoreboard.
    sb_t e;
    always @(negedge axis_aclk) begin
        if (axis_aresetn) begin
            for (int p = 0; p < 4; p++) begin
                if (m_valid[p] && m_ready[p]) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errs++;
                        $display("FAIL unexpected_beat: port %0d data %0h with empty scoreboard", p, m_data[p]);
                    end else begin
                        e = sbq.pop_front();
                        check("out_port", 32'(p), 32'(e.port));
                        check("out_data", 32'(m_data[p]), 32'(e.data));
                        check("out_last", 32'(m_last[p]), 32'(e.last));
                        if (e.chk_lat) check("latency", 32'(cyc), 32'(e.cyc));
                    end
                end
            end
            check("unpop_zero", 32'({m_valid[3:2], m_last[3:2], m_data[3], m_data[2]}), 32'd0);
        end
    end

    // Drive at posedge+1; decide acceptance at the following negedge.
    task automatic send(input logic [1:0] d, input logic [7:0] x, input logic l,
                        input int ep, input bit lc);
        int n = 0;
        @(posedge axis_aclk); #1;
        s_tdest  = d;
        s_tdata  = x;
        s_tlast  = l;
        s_tvalid = 1'b1;
        @(negedge axis_aclk);
        while (!s_tready && n < 50) begin
            n++;
            @(negedge axis_aclk);
        end
        last_wait = n;
        if (n >= 50) begin
            checks++;
            errs++;
            $display("FAIL send_timeout: beat %0h never accepted", x);
        end else if (ep >= 0) begin
            sbq.push_back('{ep, x, l, cyc + 1, lc});
        end
    endtask

    task automatic idle();
        @(posedge axis_aclk); #1;
        s_tvalid = 1'b0;
        s_tdest  = 2'd0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 20) begin
            @(negedge axis_aclk);
            n++;
        end
        @(negedge axis_aclk);
        check("drain_empty", 32'(sbq.size()), 32'd0);
    endtask

    vec_t vecs[17];
    int   exp_drops = 0;
    bit   in_pkt    = 1'b0;

    initial begin
        vecs[0]  = '{2'd1, 8'h11, 1'b0, 1};   // routing to m01
        vecs[1]  = '{2'd1, 8'h22, 1'b0, 1};
        vecs[2]  = '{2'd1, 8'h33, 1'b1, 1};
        vecs[3]  = '{2'd0, 8'h44, 1'b0, 0};   // tdest toggles mid-packet
        vecs[4]  = '{2'd1, 8'h55, 1'b0, 0};
        vecs[5]  = '{2'd1, 8'h66, 1'b1, 0};
        vecs[6]  = '{2'd3, 8'hA1, 1'b0, -1};  // invalid dest, 4 beats
        vecs[7]  = '{2'd3, 8'hA2, 1'b0, -1};
        vecs[8]  = '{2'd0, 8'hA3, 1'b0, -1};
        vecs[9]  = '{2'd3, 8'hA4, 1'b1, -1};
        vecs[10] = '{2'd0, 8'h77, 1'b1, 0};   // normal packet after drop
        vecs[11] = '{2'd0, 8'h81, 1'b1, 0};   // back-to-back 1-beat then 2-beat
        vecs[12] = '{2'd1, 8'h82, 1'b0, 1};
        vecs[13] = '{2'd1, 8'h83, 1'b1, 1};
        vecs[14] = '{2'd2, 8'h99, 1'b1, -1};  // single-beat drop
        vecs[15] = '{2'd1, 8'hB1, 1'b0, 1};
        vecs[16] = '{2'd1, 8'hB2, 1'b1, 1};

        // Reset state
        repeat (3) @(posedge axis_aclk);
        @(negedge axis_aclk);
        check("rst_tready", 32'(s_tready), 32'd0);
        check("rst_valid",  32'(m_valid),  32'd0);
        check("rst_last",   32'(m_last),   32'd0);
        check("rst_data",   32'(m_data),   32'd0);
`ifdef AXIS_SNOOP_DEMUX_STATS_EN
        check("rst_drops",  32'(drop_cnt), 32'd0);
`endif
        @(posedge axis_aclk); #1;
        axis_aresetn = 1'b1;
        @(negedge axis_aclk);
        check("idle_tready", 32'(s_tready), 32'd1);

        // Table-driven routing, all ports ready
        foreach (vecs[i]) begin
            send(vecs[i].dest, vecs[i].data, vecs[i].last, vecs[i].exp_port, 1'b1);
            if (vecs[i].exp_port < 0) check("drop_tready", 32'(last_wait), 32'd0);
            if (!in_pkt && int'(vecs[i].dest) >= NI) exp_drops++;
            in_pkt = !vecs[i].last;
        end
        idle();
        drain();
`ifdef AXIS_SNOOP_DEMUX_STATS_EN
        check("drop_count", 32'(drop_cnt), 32'(exp_drops));
`endif

        // Backpressure: m00 stalled for 5 cycles with one beat buffered
        m_ready[0] = 1'b0;
        send(2'd0, 8'hC1, 1'b0, 0, 1'b0);
        fork
            begin
                repeat (6) @(posedge axis_aclk);
                #1 m_ready[0] = 1'b1;
            end
        join_none
        send(2'd0, 8'hC2, 1'b0, 0, 1'b1);
        check("bp_stall_cycles", 32'(last_wait), 32'd5);
        send(2'd0, 8'hC3, 1'b0, 0, 1'b1);
        check("bp_no_bubble3", 32'(last_wait), 32'd0);
        send(2'd0, 8'hC4, 1'b1, 0, 1'b1);
        check("bp_no_bubble4", 32'(last_wait), 32'd0);
        idle();
        drain();

        // Reset mid-packet with a beat held in the slot
        m_ready[1] = 1'b0;
        send(2'd1, 8'hD1, 1'b0, -1, 1'b0);
        idle();
        @(negedge axis_aclk);
        check("slot_held", 32'(m_valid), 32'h2);
        #2 axis_aresetn = 1'b0;
        #1;
        check("rst_mid_valid",  32'(m_valid),  32'd0);
        check("rst_mid_tready", 32'(s_tready), 32'd0);
`ifdef AXIS_SNOOP_DEMUX_STATS_EN
        check("rst_mid_drops",  32'(drop_cnt), 32'd0);
`endif
        @(posedge axis_aclk); #1;
        axis_aresetn = 1'b1;
        m_ready = 4'hF;
        send(2'd0, 8'hE1, 1'b1, 0, 1'b1);
        send(2'd1, 8'hE2, 1'b1, 1, 1'b1);
        idle();
        drain();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/axis_snoop_demux.md
Name: axis_snoop_demux

Overview:
- Inverse of the snoop arbiter: takes one merged AXI-Stream packet stream plus a per-packet destination tag and routes each whole packet to one of up to four master ports.
- Destination is sampled on the first beat of each packet and held until tlast.
- Packets tagged for an unpopulated port are consumed and discarded.
- One registered output stage gives full throughput and a 1-cycle latency.

Parameters:
- NUM_INTERFACES, 2: number of populated master ports (1..4); ports at index >= NUM_INTERFACES are tied off.
- PORT_WIDTH, 8: tdata width in bits.

Ports:
- axis_aclk  in  1  clock
- axis_aresetn  in  1  asynchronous active-low reset
- s_axis_tdata  in  PORT_WIDTH  input beat data
- s_axis_tlast  in  1  last beat of packet
- s_axis_tvalid  in  1  input beat valid
- s_axis_tdest  in  2  destination port index; sampled only on the first beat of a packet
- s_axis_tready  out  1  input ready
- mNN_axis_tdata  out  PORT_WIDTH  output data, NN = 00..03
- mNN_axis_tlast  out  1  output last, NN = 00..03
- mNN_axis_tvalid  out  1  output valid, NN = 00..03
- mNN_axis_tready  in  1  downstream ready, NN = 00..03

Behaviour:
- Reset:
  - Asynchronous, active-low; all state clears immediately.
  - State = SOP; output register empty (out_valid=0, out_data=0, out_last=0, out_dest=0).
  - All mNN_axis_tvalid/tdata/tlast = 0.
  - s_axis_tready forced 0 while axis_aresetn=0 (gated combinationally).
- Handshakes:
  - Input beat accepted when s_axis_tvalid & s_axis_tready.
  - Output beat retired when out_valid & mNN_axis_tready[out_dest].
  - Input valid never depends on ready; output valid never depends on ready.
- Output register:
  - Single slot holding data, last, dest, valid.
  - s_axis_tready = ~out_valid | mNN_axis_tready[out_dest], except in DROP, where s_axis_tready = 1.
  - Simultaneous retire and accept in the same cycle: slot reloads, valid stays 1, no bubble.
  - Retire without accept: out_valid <= 0.
- Output mux:
  - mNN_axis_tvalid = out_valid & (out_dest == NN).
  - mNN_axis_tdata and mNN_axis_tlast = out_data and out_last when out_dest == NN, else 0.
- State machine (SOP, FWD, DROP):
  - SOP, accepted beat with s_axis_tdest < NUM_INTERFACES:
    - load slot and out_dest <= s_axis_tdest;
    - next state = SOP if tlast (single-beat packet), else FWD.
  - SOP, accepted beat with s_axis_tdest >= NUM_INTERFACES:
    - beat discarded, slot not loaded;
    - next state = SOP if tlast, else DROP.
  - FWD: accepted beats load the slot using the locked out_dest; s_axis_tdest is ignored; on accepted tlast -> SOP.
  - DROP: every beat accepted and discarded; on accepted tlast -> SOP.
  - SOP with no accepted beat: stay in SOP.
- Locked destination:
  - A new packet's first beat may enter the slot while the previous packet's tlast beat is retiring.
  - out_dest updates together with the slot load, so no beat is ever misrouted.
  - A drop-routed first beat may be accepted while the slot is still full; the slot contents are unaffected.
- Latency: 1 cycle from input acceptance to mNN_axis_tvalid.
- Unpopulated ports (index >= NUM_INTERFACES): tvalid, tdata and tlast are constant 0; their tready is ignored.
- Backpressure: a stalled destination stalls the whole input stream (head-of-line blocking); no per-port buffering.

Optional Feature:
- Macro: AXIS_SNOOP_DEMUX_STATS_EN.
- Defined:
  - Adds output drop_pkt_count [15:0].
  - Increments by 1 on each accepted SOP beat with an invalid destination.
  - Saturates at 0xFFFF; reset value 0.
- Undefined: port and counter absent; routing behaviour identical.

Decomposition:
- Package axis_snoop_pkg:
  - state enum type {SOP, FWD, DROP};
  - constants MAX_INTERFACES = 4 and DEST_W = 2;
  - shared with the arbiter.
- One sub-module, axis_snoop_out_reg: the single-slot output register with valid/ready and load/retire logic, parameterised by PORT_WIDTH and carrying dest as a sideband field.

Test Plan:
- Routing: NUM_INTERFACES=2, all tready=1; send 3-beat packet tdest=1, data 0x11,0x22,0x33 -> m01 carries exactly 0x11,0x22,0x33 with tlast on the third beat, one cycle after each input; m00 tvalid stays 0.
- Mid-packet tdest change: packet starts with tdest=0, then tdest is toggled to 1 on beats 2 and 3 -> all beats appear on m00.
- Invalid destination: 4-beat packet with tdest=3 at NUM_INTERFACES=2 -> s_axis_tready=1 every beat; no output activity; drop_pkt_count 0->1 when STATS_EN is defined. A following packet with tdest=0 routes normally.
- Backpressure: hold m00_axis_tready=0 for 5 cycles mid-packet -> s_axis_tready=0 after one beat is buffered; beat order preserved; on release, full throughput resumes with no bubble.
- Back-to-back packets: single-beat packet to port 0 immediately followed by a 2-beat packet to port 1, all tready=1 -> three consecutive output cycles, each beat on the correct port.
- Reset mid-packet: assert axis_aresetn=0 while a beat is in the slot -> all mNN_tvalid drop to 0 immediately and s_axis_tready=0. After release, the state is SOP and the next beat's tdest is honoured.
